// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory access arbiter.
package dm_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 64;
  localparam int MEM_BYTES = 226;
  localparam int DW_BYTES  = 8;

  // Highest start address whose double word still fits inside memory.
  localparam logic [ADDR_W-1:0] LAST_DW_ADDR = ADDR_W'(MEM_BYTES - DW_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/dm_access_arbiter_if.sv
// One requester port of the data-memory arbiter.
// master: the requester (pipeline MEM stage or loader); slave: the arbiter.
interface dm_access_arbiter_if;
  import dm_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);

endinterface

// File: rtl/dm_arb_select.sv
// Grant selection between requesters A and B, evaluated while the FSM is idle.
// Build option DM_ARB_ROUND_ROBIN_EN: strict round-robin on contention;
// otherwise fixed priority A > B with a starvation limit for B.
module dm_arb_select
  import dm_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   arb_en,
  input  logic   a_req,
  input  logic   b_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

  assign grant_valid = a_req | b_req;

`ifdef DM_ARB_ROUND_ROBIN_EN

  owner_t last_owner;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant_owner = OWN_A;
    if (a_req && b_req) begin
      grant_owner = (last_owner == OWN_A) ? OWN_B : OWN_A;
    end else if (b_req) begin
      grant_owner = OWN_B;
    end
  end

  // Remember the last winner; reset value lets A win the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_owner <= OWN_B;
    end else if (arb_en && grant_valid) begin
      last_owner <= grant_owner;
    end
  end

`else

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;

  // Fixed priority for A unless B has been passed over LIMIT times in a row.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grant_owner = OWN_A;
    starve_nxt  = starve_cnt;
    if (b_req && (!a_req || starve_cnt == LIMIT)) begin
      grant_owner = OWN_B;
      starve_nxt  = '0;
    end else if (a_req) begin
      starve_nxt = b_req ? starve_cnt + 1'b1 : '0;
    end else begin
      starve_nxt = '0;
    end
  end

  // Starvation counter only moves when the FSM is arbitrating.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      starve_cnt <= starve_nxt;
    end
  end

`endif

endmodule

// File: rtl/dm_access_arbiter.sv
// Shares one 64-bit big-endian data memory between requester A (pipeline MEM
// stage) and requester B (loader/debug) through an IDLE/ACCESS/RESP sequence.
// Build option DM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module dm_access_arbiter
  import dm_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  dm_access_arbiter_if.slave a,
  dm_access_arbiter_if.slave b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Every output comes straight from this register set.
  typedef struct packed {
    state_t            state;
    owner_t            owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_err;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;
    logic              busy;
  } regs_t;

  regs_t  cur;
  regs_t  nxt;
  logic   arb_en;
  logic   grant_valid;
  owner_t grant_owner;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign arb_en = (cur.state == IDLE);

  dm_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clock      (clock),
    .reset      (reset),
    .arb_en     (arb_en),
    .a_req      (a.req),
    .b_req      (b.req),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  assign sel_we    = (grant_owner == OWN_A) ? a.we    : b.we;
  assign sel_addr  = (grant_owner == OWN_A) ? a.addr  : b.addr;
  assign sel_wdata = (grant_owner == OWN_A) ? a.wdata : b.wdata;

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    nxt = cur;
    unique case (cur.state)
      IDLE: begin
        if (grant_valid) begin
          nxt.owner = grant_owner;
          nxt.we    = sel_we;
          nxt.addr  = sel_addr;
          nxt.wdata = sel_wdata;
          nxt.busy  = 1'b1;
          if (sel_addr <= LAST_DW_ADDR) begin
            nxt.rd    = ~sel_we;
            nxt.wr    = sel_we;
            nxt.state = ACCESS;
          end else begin
            // Out-of-range double word: answer with an error, never strobe memory.
            nxt.state = RESP;
            if (grant_owner == OWN_A) begin
              nxt.a_ack   = 1'b1;
              nxt.a_err   = 1'b1;
              nxt.a_rdata = '0;
            end else begin
              nxt.b_ack   = 1'b1;
              nxt.b_err   = 1'b1;
              nxt.b_rdata = '0;
            end
          end
        end
      end
      ACCESS: begin
        // Write commits and read data is captured at the edge ending this cycle.
        nxt.rd    = 1'b0;
        nxt.wr    = 1'b0;
        nxt.state = RESP;
        if (cur.owner == OWN_A) begin
          nxt.a_ack   = 1'b1;
          nxt.a_err   = 1'b0;
          nxt.a_rdata = cur.we ? '0 : mem_rdata;
        end else begin
          nxt.b_ack   = 1'b1;
          nxt.b_err   = 1'b0;
          nxt.b_rdata = cur.we ? '0 : mem_rdata;
        end
      end
      RESP: begin
        nxt.state   = IDLE;
        nxt.busy    = 1'b0;
        nxt.a_ack   = 1'b0;
        nxt.a_err   = 1'b0;
        nxt.a_rdata = '0;
        nxt.b_ack   = 1'b0;
        nxt.b_err   = 1'b0;
        nxt.b_rdata = '0;
      end
      default: begin
        nxt.state = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access without an ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur <= '0;
    end else begin
      cur <= nxt;
    end
  end

  assign a.ack     = cur.a_ack;
  assign a.rdata   = cur.a_rdata;
  assign a.err     = cur.a_err;
  assign b.ack     = cur.b_ack;
  assign b.rdata   = cur.b_rdata;
  assign b.err     = cur.b_err;
  assign mem_addr  = cur.addr;
  assign mem_wdata = cur.wdata;
  assign mem_read  = cur.rd;
  assign mem_write = cur.wr;
  assign busy      = cur.busy;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter with a byte-array memory and a
// reference model of memory contents, latency and arbitration order.
module tb_dm_access_arbiter;
  import dm_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  dm_access_arbiter_if a_if ();
  dm_access_arbiter_if b_if ();

  dm_access_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .a        (a_if),
    .b        (b_if),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Memory under the arbiter, plus the model of what it should contain.
  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  bit         preload = 1'b0;
  int         rd_cnt  = 0;
  int         wr_cnt  = 0;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'hAA;
    end else if (mem_write) begin
      for (int i = 0; i < DW_BYTES; i++)
        if (int'(mem_addr) + i < MEM_BYTES)
          mem[int'(mem_addr) + i] <= mem_wdata[DATA_W-1-8*i -: 8];
    end
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
  end

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < DW_BYTES; i++)
      if (int'(mem_addr) + i < MEM_BYTES)
        mem_rdata[DATA_W-1-8*i -: 8] = mem[int'(mem_addr) + i];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_legal(input int addr);
    return (addr + DW_BYTES) <= MEM_BYTES;
  endfunction

  function automatic logic [63:0] ref_read(input int addr);
    logic [63:0] d = '0;
    for (int i = 0; i < DW_BYTES; i++) d = {d[55:0], ref_mem[addr + i]};
    return d;
  endfunction

  function automatic void ref_write(input int addr, input logic [63:0] d);
    for (int i = 0; i < DW_BYTES; i++) ref_mem[addr + i] = d[63-8*i -: 8];
  endfunction

  function automatic logic [63:0] mem_dw(input int addr);
    logic [63:0] d = '0;
    for (int i = 0; i < DW_BYTES; i++) d = {d[55:0], mem[addr + i]};
    return d;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input bit pb, input bit req, input bit we,
                          input logic [7:0] addr, input logic [63:0] wdata);
    if (pb) begin
      b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
    end else begin
      a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
    end
  endtask

  task automatic apply_reset(input bit fill);
    reset   = 1'b1;
    preload = fill;
    set_port(1'b0, 1'b0, 1'b0, 8'd0, 64'd0);
    set_port(1'b1, 1'b0, 1'b0, 8'd0, 64'd0);
    tick();
    tick();
    preload = 1'b0;
    reset   = 1'b0;
    if (fill) for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'hAA;
  endtask

  // One access from an idle FSM; ack_cycle counts the req cycle as cycle 1, 0 = no ack.
  task automatic run_access(input bit pb, input bit we, input logic [7:0] addr,
                            input logic [63:0] wdata, output logic [63:0] rdata,
                            output logic err, output int ack_cycle,
                            output int rd_pulses, output int wr_pulses,
                            output bit other_ack);
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    rdata = 'x; err = 1'bx; ack_cycle = 0; other_ack = 1'b0;
    set_port(pb, 1'b1, we, addr, wdata);
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (pb ? a_if.ack : b_if.ack) other_ack = 1'b1;
      if (pb ? b_if.ack : a_if.ack) begin
        ack_cycle = c;
        rdata     = pb ? b_if.rdata : a_if.rdata;
        err       = pb ? b_if.err : a_if.err;
        break;
      end
    end
    set_port(pb, 1'b0, 1'b0, 8'd0, 64'd0);
    rd_pulses = rd_cnt - r0;
    wr_pulses = wr_cnt - w0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    checks++;
    if ({a_if.ack, a_if.err, b_if.ack, b_if.err, mem_read, mem_write, busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {a_if.ack, a_if.err, b_if.ack, b_if.err, mem_read, mem_write, busy});
    end
    checks++;
    if ({a_if.rdata, b_if.rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got a=%h b=%h addr=%h wdata=%h expected all 0",
               a_if.rdata, b_if.rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_write_read();
    logic [63:0] rd; logic er; int cyc, rp, wp; bit oth;
    run_access(1'b0, 1'b1, 8'd40, 64'h0123456789ABCDEF, rd, er, cyc, rp, wp, oth);
    ref_write(40, 64'h0123456789ABCDEF);
    checks++;
    if (cyc !== 3 || er !== 1'b0 || rd !== 64'd0 || wp !== 1 || oth) begin
      errors++;
      $display("FAIL a_write: got cyc=%0d err=%b rdata=%h wpulses=%0d other=%b expected 3 0 0 1 0",
               cyc, er, rd, wp, oth);
    end
    checks++;
    if (mem_dw(40) !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL a_write_bytes: got %h expected 0123456789abcdef", mem_dw(40));
    end
    run_access(1'b0, 1'b0, 8'd40, 64'd0, rd, er, cyc, rp, wp, oth);
    checks++;
    if (cyc !== 3 || er !== 1'b0 || rd !== 64'h0123456789ABCDEF || rp !== 1) begin
      errors++;
      $display("FAIL a_read: got cyc=%0d err=%b rdata=%h rpulses=%0d expected 3 0 0123456789abcdef 1",
               cyc, er, rd, rp);
    end
  endtask

  task automatic test_b_read();
    logic [63:0] rd; logic er; int cyc, rp, wp; bit oth;
    run_access(1'b1, 1'b0, 8'd80, 64'd0, rd, er, cyc, rp, wp, oth);
    checks++;
    if (cyc !== 3 || er !== 1'b0 || rd !== 64'hAAAAAAAAAAAAAAAA) begin
      errors++;
      $display("FAIL b_read: got cyc=%0d err=%b rdata=%h expected 3 0 aaaaaaaaaaaaaaaa", cyc, er, rd);
    end
    checks++;
    if (rp !== 1 || wp !== 0 || oth) begin
      errors++;
      $display("FAIL b_read_strobe: got rpulses=%0d wpulses=%0d a_ack=%b expected 1 0 0", rp, wp, oth);
    end
  endtask

  task automatic test_boundary();
    logic [63:0] rd; logic er; int cyc, rp, wp; bit oth;
    logic [55:0] tail_before;
    run_access(1'b0, 1'b0, 8'd218, 64'd0, rd, er, cyc, rp, wp, oth);
    checks++;
    if (cyc !== 3 || er !== 1'b0 || rd !== ref_read(218) || rp !== 1) begin
      errors++;
      $display("FAIL read_218: got cyc=%0d err=%b rdata=%h rp=%0d expected 3 0 %h 1",
               cyc, er, rd, rp, ref_read(218));
    end
    tail_before = {ref_mem[219], ref_mem[220], ref_mem[221], ref_mem[222],
                   ref_mem[223], ref_mem[224], ref_mem[225]};
    run_access(1'b0, 1'b1, 8'd219, 64'h1122334455667788, rd, er, cyc, rp, wp, oth);
    checks++;
    if (cyc !== 2 || er !== 1'b1 || rd !== 64'd0 || wp !== 0 || rp !== 0) begin
      errors++;
      $display("FAIL write_219: got cyc=%0d err=%b rdata=%h wp=%0d rp=%0d expected 2 1 0 0 0",
               cyc, er, rd, wp, rp);
    end
    checks++;
    if ({mem[219], mem[220], mem[221], mem[222], mem[223], mem[224], mem[225]} !== tail_before) begin
      errors++;
      $display("FAIL tail_bytes: got %h expected %h",
               {mem[219], mem[220], mem[221], mem[222], mem[223], mem[224], mem[225]}, tail_before);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  rd_seq = '0;
    int          ack_ticks[$];
    logic [63:0] data[$];
    set_port(1'b0, 1'b1, 1'b0, 8'd40, 64'd0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) rd_seq = {rd_seq[2:0], mem_read};
      if (a_if.ack) begin
        ack_ticks.push_back(c);
        data.push_back(a_if.rdata);
      end
      if (c == 5) set_port(1'b0, 1'b0, 1'b0, 8'd0, 64'd0);
    end
    tick();
    checks++;
    if (rd_seq !== 4'b1001) begin
      errors++;
      $display("FAIL b2b_strobe: got mem_read %b expected 1001", rd_seq);
    end
    checks++;
    if (ack_ticks.size() != 2 || ack_ticks[0] != 2 || ack_ticks[1] != 5) begin
      errors++;
      $display("FAIL b2b_acks: got %0d acks expected 2 at cycles 3 and 6", ack_ticks.size());
    end
    for (int k = 0; k < data.size(); k++) begin
      checks++;
      if (data[k] !== ref_read(40)) begin
        errors++;
        $display("FAIL b2b_data%0d: got %h expected %h", k, data[k], ref_read(40));
      end
    end
  endtask

  task automatic test_contention();
    int order[$];
    int ack_at[$];
    int exp_owner;
    int cnt = 0;
    apply_reset(1'b1);
    set_port(1'b0, 1'b1, 1'b0, 8'd8, 64'd0);
    set_port(1'b1, 1'b1, 1'b0, 8'd16, 64'd0);
    for (int c = 1; c <= 40 && order.size() < 10; c++) begin
      tick();
      if (a_if.ack) begin order.push_back(0); ack_at.push_back(c); end
      if (b_if.ack) begin order.push_back(1); ack_at.push_back(c); end
    end
    set_port(1'b0, 1'b0, 1'b0, 8'd0, 64'd0);
    set_port(1'b1, 1'b0, 1'b0, 8'd0, 64'd0);
    tick();
    tick();
    checks++;
    if (order.size() != 10) begin
      errors++;
      $display("FAIL contention_count: got %0d grants expected 10", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
      exp_owner = k % 2;
`else
      if (cnt == STARVE_LIMIT) begin exp_owner = 1; cnt = 0; end
      else begin exp_owner = 0; cnt++; end
`endif
      checks++;
      if (order[k] != exp_owner || ack_at[k] != 2 + 3 * k) begin
        errors++;
        $display("FAIL contention_grant%0d: got owner=%0d tick=%0d expected owner=%0d tick=%0d",
                 k, order[k], ack_at[k], exp_owner, 2 + 3 * k);
      end
    end
  endtask

  task automatic test_reset_in_access();
    logic [63:0] v = {$urandom, $urandom};
    set_port(1'b0, 1'b1, 1'b1, 8'd0, v);
    tick();
    checks++;
    if (mem_write !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_access_entry: got mem_write=%b busy=%b expected 1 1", mem_write, busy);
    end
    reset = 1'b1;
    tick();
    set_port(1'b0, 1'b0, 1'b0, 8'd0, 64'd0);
    checks++;
    if ({a_if.ack, b_if.ack, a_if.err, b_if.err, mem_read, mem_write, busy} !== 7'd0 ||
        {a_if.rdata, b_if.rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: got ack=%b mem_write=%b busy=%b addr=%h expected all 0",
               a_if.ack, mem_write, busy, mem_addr);
    end
    reset = 1'b0;
    ref_write(0, v);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (a_if.ack !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_ack: got a_ack=%b expected 0", a_if.ack);
      end
    end
    checks++;
    if (mem_dw(0) !== v) begin
      errors++;
      $display("FAIL rst_write_commit: got %h expected %h", mem_dw(0), v);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, wd, exp_rd; logic er; int cyc, rp, wp; bit oth;
    bit pb, we, legal;
    logic [7:0] addr;
    for (int n = 0; n < 40; n++) begin
      pb = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       addr = 8'd218;
        1:       addr = 8'd219;
        2:       addr = 8'($urandom_range(219, 255));
        default: addr = 8'($urandom_range(0, 218));
      endcase
      legal  = ref_legal(int'(addr));
      exp_rd = (legal && !we) ? ref_read(int'(addr)) : 64'd0;
      run_access(pb, we, addr, wd, rd, er, cyc, rp, wp, oth);
      if (legal && we) ref_write(int'(addr), wd);
      checks++;
      if (cyc !== (legal ? 3 : 2) || er !== !legal || rd !== exp_rd || oth) begin
        errors++;
        $display("FAIL rand%0d port=%0d we=%0d addr=%0d: got cyc=%0d err=%b rdata=%h other=%b expected %0d %b %h 0",
                 n, pb, we, addr, cyc, er, rd, oth, legal ? 3 : 2, !legal, exp_rd);
      end
      checks++;
      if (rp !== int'(legal && !we) || wp !== int'(legal && we)) begin
        errors++;
        $display("FAIL rand%0d_strobes: got rp=%0d wp=%0d expected %0d %0d",
                 n, rp, wp, int'(legal && !we), int'(legal && we));
      end
    end
  endtask

  task automatic test_final_memory();
    int bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL final_memory: got %0d differing bytes expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_b_read();
    test_boundary();
    test_back_to_back();
    test_contention();
    test_reset_in_access();
    test_random();
    test_final_memory();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
